// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: fixed-latency multiply, radix-2 restoring divide.
// Optional multiply-accumulate ops (4-7) are built only when MDU_MADD_EN is defined.
module mdu_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic             We,
    input  logic             HiLo,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAXN = (MUL_CYCLES > WIDTH + 1) ? MUL_CYCLES : WIDTH + 1;
    localparam int CW   = $clog2(MAXN + 1);
    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_reg, b_reg, quo, rem, hi_reg, lo_reg;
    logic               op_signed;
    logic               done_reg;
`ifdef MDU_MADD_EN
    logic               op_mac, op_sub;
`endif

    logic               op_ok, accept, mul_done, div_done;
    logic [WIDTH-1:0]   a_mag_in, b_mag;
    logic [WIDTH:0]     shifted, diff;
    logic [2*WIDTH-1:0] ext_a, ext_b, product, mul_result;
    logic [WIDTH-1:0]   div_hi, div_lo;
    logic               neg_q, neg_r;

    // Op acceptance and completion qualifiers; Cancel always beats completion.
    always_comb begin
`ifdef MDU_MADD_EN
        op_ok = 1'b1;
`else
        op_ok = ~Op[2];
`endif
        accept   = (state == IDLE) && Start && !Cancel && op_ok;
        mul_done = (state == MUL) && !Cancel && (cnt == MUL_LAST);
        div_done = (state == DIV) && !Cancel && (cnt == DIV_LAST);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (Op[2:1] == 2'b01) ? DIV : MUL;
            MUL:  if (Cancel || mul_done) state_next = IDLE;
            DIV:  if (Cancel || div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    // Dividend magnitude is loaded straight into the quotient shift register.
    always_comb begin
        a_mag_in = (Op[0] && D1[WIDTH-1]) ? -D1 : D1;
        b_mag    = (op_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, b_mag};
    end

    always_comb begin
        ext_a   = op_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
        ext_b   = op_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
        product = ext_a * ext_b;
`ifdef MDU_MADD_EN
        if (op_mac)
            mul_result = op_sub ? ({hi_reg, lo_reg} - product) : ({hi_reg, lo_reg} + product);
        else
            mul_result = product;
`else
        mul_result = product;
`endif
    end

    // Sign fix; the most-negative / -1 case falls out of the magnitude path unchanged.
    always_comb begin
        neg_q = op_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
        neg_r = op_signed & a_reg[WIDTH-1];
        if (b_reg == '0) begin
            div_hi = a_reg;
            div_lo = '1;
        end else begin
            div_hi = neg_r ? -rem : rem;
            div_lo = neg_q ? -quo : quo;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            quo       <= '0;
            rem       <= '0;
            op_signed <= 1'b0;
`ifdef MDU_MADD_EN
            op_mac    <= 1'b0;
            op_sub    <= 1'b0;
`endif
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= mul_done | div_done;

            if (accept)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + CW'(1);

            if (accept) begin
                a_reg     <= D1;
                b_reg     <= D2;
                op_signed <= Op[0];
`ifdef MDU_MADD_EN
                op_mac    <= Op[2];
                op_sub    <= Op[1];
`endif
                quo       <= a_mag_in;
                rem       <= '0;
            end else if (state == DIV && cnt != DIV_LAST) begin
                if (diff[WIDTH]) begin
                    rem <= shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end else begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end
            end

            if (state == IDLE && We) begin
                if (HiLo) hi_reg <= D1;
                else      lo_reg <= D1;
            end else if (mul_done) begin
                {hi_reg, lo_reg} <= mul_result;
            end else if (div_done) begin
                hi_reg <= div_hi;
                lo_reg <= div_lo;
            end
        end
    end

    assign Busy = (state != IDLE);
    assign Done = done_reg;
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter (WIDTH=32, MUL_CYCLES=5); MAC checks follow MDU_MADD_EN.
module tb_mdu_iter;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam logic [2:0] OP_MULTU = 3'd0, OP_MULT = 3'd1, OP_DIVU = 3'd2, OP_DIV = 3'd3,
                           OP_MADDU = 3'd4, OP_MADD = 3'd5, OP_MSUBU = 3'd6, OP_MSUB = 3'd7;

    logic         Clk = 1'b0;
    logic         Rst, Start, We, HiLo, Cancel;
    logic [2:0]   Op;
    logic [W-1:0] D1, D2;
    logic         Busy, Done;
    logic [W-1:0] HI, LO;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [31:0] modelHi, modelLo;

    mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .D1(D1), .D2(D2),
        .We(We), .HiLo(HiLo), .Cancel(Cancel), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    // Reference behaviour written with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        int          ia, ib, q, r;
        longint      la, lb;
        logic [63:0] p;
        ia = a;
        ib = b;
        case (op)
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                q = ia / ib;
                r = ia % ib;
                return {32'(r), 32'(q)};
            end
            default: begin
                if (op[0]) begin
                    la = ia;
                    lb = ib;
                    p  = la * lb;
                end else begin
                    p = {32'h0, a} * {32'h0, b};
                end
                if (op == OP_MADDU || op == OP_MADD) return {hi, lo} + p;
                if (op == OP_MSUBU || op == OP_MSUB) return {hi, lo} - p;
                return p;
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        D1    = a;
        D2    = b;
        tick();
        Start  = 1'b0;
        We     = 1'b0;
        Cancel = 1'b0;
    endtask

    // Counts Busy cycles; optionally injects a Start (kind 1) or We (kind 2) on one busy cycle.
    task automatic waitDone(input string tag, input int expBusy, input int actCycle, input int actKind);
        int n = 0;
        while (Busy && n < 200) begin
            n++;
            if (n == actCycle && actKind == 1) begin
                Start = 1'b1; Op = OP_MULTU; D1 = 32'h5; D2 = 32'h5;
            end else if (n == actCycle && actKind == 2) begin
                We = 1'b1; HiLo = 1'b1; D1 = 32'hDEAD;
            end
            tick();
            Start = 1'b0;
            We    = 1'b0;
        end
        checkOutput({tag, " busy cycles"}, 64'(n), 64'(expBusy));
        checkOutput({tag, " done"}, 64'(Done), 64'd1);
        tick();
        checkOutput({tag, " done drop"}, 64'(Done), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int expBusy, input int actCycle = 0, input int actKind = 0);
        sb.push_back(exp);
        applyStimulus(op, a, b);
        waitDone(tag, expBusy, actCycle, actKind);
        modelHi = exp[63:32];
        modelLo = exp[31:0];
    endtask

    // Result monitor: every Done must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (!Rst && Done) begin
            if (sb.size() == 0) begin
                checkOutput("spurious done", 64'(Done), 64'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                checkOutput("result hi", 64'(HI), 64'(e[63:32]));
                checkOutput("result lo", 64'(LO), 64'(e[31:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        Rst = 1'b1; Start = 1'b0; We = 1'b0; HiLo = 1'b0; Cancel = 1'b0;
        Op = 3'd0; D1 = '0; D2 = '0;
        modelHi = '0; modelLo = '0;
        repeat (2) tick();
        checkOutput("reset hi",   64'(HI),   64'd0);
        checkOutput("reset lo",   64'(LO),   64'd0);
        checkOutput("reset busy", 64'(Busy), 64'd0);
        checkOutput("reset done", 64'(Done), 64'd0);
        Rst = 1'b0;
        tick();

        runOp("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);
        runOp("mult -3*7", OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 5);
        runOp("div -7/2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 33);
        runOp("divu 7/0",  OP_DIVU,  32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, 33);
        runOp("div ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
        runOp("div 7/-2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);
        runOp("div -9/0",  OP_DIV,   32'hFFFF_FFF7, 32'd0,         64'hFFFF_FFF7_FFFF_FFFF, 33);
        runOp("divu start ignored", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, 5, 1);

        // Cancel on the 10th busy cycle of a divide.
        applyStimulus(OP_DIVU, 32'd100, 32'd3);
        repeat (9) tick();
        Cancel = 1'b1;
        tick();
        Cancel = 1'b0;
        checkOutput("cancel div busy", 64'(Busy), 64'd0);
        checkOutput("cancel div hi",   64'(HI),   64'(modelHi));
        checkOutput("cancel div lo",   64'(LO),   64'(modelLo));
        repeat (40) tick();
        checkOutput("cancel div idle", 64'(Busy), 64'd0);

        // Cancel coincident with multiply completion wins.
        applyStimulus(OP_MULTU, 32'h1000, 32'h1000);
        repeat (4) tick();
        Cancel = 1'b1;
        tick();
        Cancel = 1'b0;
        checkOutput("cancel at end busy", 64'(Busy), 64'd0);
        checkOutput("cancel at end done", 64'(Done), 64'd0);
        checkOutput("cancel at end lo",   64'(LO),   64'(modelLo));

        We = 1'b1; HiLo = 1'b1; D1 = 32'h1234;
        tick();
        We = 1'b0;
        modelHi = 32'h1234;
        checkOutput("mthi hi",   64'(HI),   64'h1234);
        checkOutput("mthi lo",   64'(LO),   64'(modelLo));
        checkOutput("mthi busy", 64'(Busy), 64'd0);

        // Write during Busy is dropped; cancel so no result overwrites HI.
        applyStimulus(OP_MULTU, 32'd9, 32'd9);
        We = 1'b1; HiLo = 1'b1; D1 = 32'hDEAD;
        tick();
        We = 1'b0;
        checkOutput("we busy hi", 64'(HI), 64'(modelHi));
        Cancel = 1'b1;
        tick();
        Cancel = 1'b0;
        checkOutput("we busy hi after", 64'(HI), 64'(modelHi));

        // Cancel in IDLE blocks Start but not We.
        Cancel = 1'b1; We = 1'b1; HiLo = 1'b0;
        applyStimulus(OP_MULTU, 32'h55, 32'h2);
        modelLo = 32'h55;
        checkOutput("idle cancel busy", 64'(Busy), 64'd0);
        checkOutput("idle cancel lo",   64'(LO),   64'h55);
        checkOutput("idle cancel hi",   64'(HI),   64'(modelHi));
        tick();
        checkOutput("idle cancel done", 64'(Done), 64'd0);

        // We together with Start: write lands, then the product replaces it.
        We = 1'b1; HiLo = 1'b1;
        sb.push_back(64'h0000_0000_0000_0030);
        applyStimulus(OP_MULTU, 32'h10, 32'h3);
        checkOutput("we+start hi", 64'(HI), 64'h10);
        waitDone("we+start", 5, 0, 0);
        modelHi = 32'h0; modelLo = 32'h30;

        We = 1'b1; HiLo = 1'b1; D1 = 32'h0;
        tick();
        HiLo = 1'b0; D1 = 32'd5;
        tick();
        We = 1'b0;
        modelHi = 32'h0; modelLo = 32'd5;
`ifdef MDU_MADD_EN
        runOp("madd 3*-2", OP_MADD, 32'd3, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 5);
        We = 1'b1; HiLo = 1'b0;
        sb.push_back(64'hFFFF_FFFF_0000_0010);
        applyStimulus(OP_MADDU, 32'd4, 32'd3);
        waitDone("we+maddu", 5, 0, 0);
        modelHi = 32'hFFFF_FFFF; modelLo = 32'h10;
        runOp("msubu", OP_MSUBU, 32'd2, 32'd10, 64'hFFFF_FFFE_FFFF_FFFC, 5);
        runOp("msub", OP_MSUB, 32'd7, 32'hFFFF_FFFD, model(OP_MSUB, 32'd7, 32'hFFFF_FFFD, modelHi, modelLo), 5);
`else
        applyStimulus(OP_MADD, 32'd3, 32'hFFFF_FFFE);
        checkOutput("madd off busy", 64'(Busy), 64'd0);
        repeat (6) tick();
        checkOutput("madd off busy later", 64'(Busy), 64'd0);
        checkOutput("madd off hi", 64'(HI), 64'h0);
        checkOutput("madd off lo", 64'(LO), 64'd5);
        applyStimulus(OP_MSUBU, 32'd2, 32'd10);
        checkOutput("msubu off busy", 64'(Busy), 64'd0);
        checkOutput("msubu off lo", 64'(LO), 64'd5);
`endif

        // Reset mid-multiply on busy cycle 3.
        We = 1'b1; HiLo = 1'b1; D1 = 32'hABCD;
        tick();
        We = 1'b0;
        applyStimulus(OP_MULT, 32'hFFFF_FFF0, 32'd7);
        repeat (2) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        checkOutput("midreset hi",   64'(HI),   64'd0);
        checkOutput("midreset lo",   64'(LO),   64'd0);
        checkOutput("midreset busy", 64'(Busy), 64'd0);
        checkOutput("midreset done", 64'(Done), 64'd0);
        modelHi = '0; modelLo = '0;
        runOp("mult after reset", OP_MULT, 32'd2, 32'd3, 64'h0000_0000_0000_0006, 5);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = rop[1] ? 32'($urandom_range(0, 70000)) : $urandom;
            if (i == 5) rb = 32'hFFFF_FFFF;
            runOp("random", rop, ra, rb, model(rop, ra, rb, modelHi, modelLo), rop[1] ? 33 : 5);
        end

        tick();
        checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
